flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares the single `flash` block interface (block_addr/data_i/data_o/we_i/rd_i/ack_o) between NUM_REQ requesters, e.g. CPU fetch port and a boot/DMA copier.
- Round-robin arbitration, one transaction in flight.
- Holds the flash strobe stable until ack, then returns a one-cycle ack to the winner.
- Sits between the bus masters and the `flash` instance; the BPI pins remain inside `flash`.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 26, block address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles (used only with FLASH_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_rd  in  NUM_REQ  per-requester read request, level, held until req_ack.
- req_we  in  NUM_REQ  per-requester write request, level, held until req_ack.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  NUM_REQ  one-cycle error pulse coincident with req_ack (timeout).
- req_rdata  out  DATA_W  read data, shared; valid in the req_ack cycle.
- flash_block_addr  out  ADDR_W  drives flash.block_addr.
- flash_wdata  out  DATA_W  drives flash.data_i.
- flash_we  out  1  drives flash.we_i.
- flash_rd  out  1  drives flash.rd_i.
- flash_ack  in  1  from flash.ack_o.
- flash_rdata  in  DATA_W  from flash.data_o.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, rr_ptr=0, grant index 0.
  - A mid-transaction reset drops flash_we/flash_rd immediately.
  - No ack is issued for the aborted transaction.
- Pending vector: pend[i] = req_rd[i] | req_we[i]. If both bits are set for one requester, it is a write.
- IDLE:
  - If pend != 0, pick the first set bit searching from rr_ptr upward with wrap.
  - Register grant index g, address, wdata and op; go to BUSY.
  - The flash strobe, address and data are valid from the next cycle.
  - Latency: request sampled at cycle T, flash_we/flash_rd high at T+1.
- BUSY:
  - flash_we/flash_rd, flash_block_addr and flash_wdata are held constant.
  - Requester inputs are ignored, including the granted one dropping its request; the transaction still completes.
  - On flash_ack=1 at cycle A:
    - at A+1, strobes are low, req_ack[g]=1, and req_rdata = flash_rdata captured at A (reads only; writes leave req_rdata unchanged);
    - rr_ptr = (g+1) mod NUM_REQ;
    - go to RECOVER.
- RECOVER: exactly one cycle with strobes low (the req_ack cycle), then IDLE.
  - Requester contract: request low from the cycle after req_ack.
  - Requests still present in IDLE are treated as new.
- flash_ack in IDLE or RECOVER is ignored.
- Simultaneous requests from all requesters: strict rotation. With NUM_REQ=2 and both continuously pending, grants alternate 0,1,0,1...
- A new request arriving during BUSY is queued by level only; it is arbitrated at the next IDLE.
- Throughput: minimum 3 cycles per transaction plus the flash latency.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no flash_ack: strobes drop, req_ack[g] and req_err[g] pulse together next cycle, req_rdata=0, rr_ptr advances, go to RECOVER.
  - A flash_ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; req_err is tied to 0.

Decomposition:
- Shared flash_pkg:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RECOVER=2'd2);
  - FLASH_ADDR_W=26 and FLASH_DATA_W=32 defaults;
  - TIMEOUT_ERR_DATA=0.
- Sub-module rr_picker: combinational round-robin.
  - Inputs: pend[NUM_REQ], ptr.
  - Outputs: valid, idx.
  - Reusable by other arbiters.

Test Plan:
- Single read: req_rd[0]=1, addr=26'h12, flash_ack after 5 cycles with flash_rdata=32'hCAFEF00D -> flash_rd high at T+1 with flash_block_addr=26'h12; req_ack[0] one cycle, req_rdata=32'hCAFEF00D; flash_rd low in ack cycle.
- Contention: req_rd[0] and req_we[1] asserted together for 4 transactions -> grant order 0,1,0,1; flash_we only during requester-1 grants with flash_wdata = req_wdata[1].
- Stability: requester 0 changes addr and drops req_rd mid-BUSY -> flash_block_addr unchanged, ack still delivered, no second transaction.
- Async reset: rst=0 pulsed in BUSY -> flash_rd low without a clock edge, req_ack never pulses; after release, rr_ptr=0 and requester 0 wins a tie.
- Stray ack: flash_ack=1 while IDLE -> no req_ack, no state change.
- With FLASH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no flash_ack -> after 16 BUSY cycles req_ack[0]=req_err[0]=1, req_rdata=0, strobe low; next request serviced normally.

Source files
------------

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared state encoding, width defaults and helpers for the flash arbiter slice.
package flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_e;

  localparam int FLASH_ADDR_W     = 26;
  localparam int FLASH_DATA_W     = 32;
  localparam int TIMEOUT_ERR_DATA = 0;

  // Round-robin successor of grant index g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// rtl/flash_arbiter_if.sv - arbiter-to-flash block interface; master = arbiter, slave = flash.
interface flash_arbiter_if #(
  parameter int ADDR_W = flash_pkg::FLASH_ADDR_W,
  parameter int DATA_W = flash_pkg::FLASH_DATA_W
) ();

  logic [ADDR_W-1:0] flash_block_addr;
  logic [DATA_W-1:0] flash_wdata;
  logic              flash_we;
  logic              flash_rd;
  logic              flash_ack;
  logic [DATA_W-1:0] flash_rdata;

  modport master (
    output flash_block_addr,
    output flash_wdata,
    output flash_we,
    output flash_rd,
    input  flash_ack,
    input  flash_rdata
  );

  modport slave (
    input  flash_block_addr,
    input  flash_wdata,
    input  flash_we,
    input  flash_rd,
    output flash_ack,
    output flash_rdata
  );

endinterface

// File: rtl/flash_arbiter_rr_picker.sv
// rtl/flash_arbiter_rr_picker.sv - combinational round-robin picker: first pending index at or after ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset back to ptr so the nearest hit is the last assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend[(int'(ptr) + k) % NUM_REQ]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - round-robin arbiter sharing one flash block port among NUM_REQ requesters.
// Optional busy watchdog enabled with FLASH_ARB_TIMEOUT_EN.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = FLASH_ADDR_W,
  parameter int DATA_W         = FLASH_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_rdata,
  flash_arbiter_if.master           flash
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("flash_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..65535");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rd_q, rd_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                complete;

  logic [NUM_REQ-1:0]  pend;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
`endif

  // A requester with both bits set is treated as a write.
  assign pend = req_rd | req_we;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .pend  (pend),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rd_d     = rd_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    complete = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          we_d    = req_we[pick_idx];
          rd_d    = ~req_we[pick_idx];
          state_d = ST_BUSY;
`ifdef FLASH_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef FLASH_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        // A real ack takes priority over a watchdog expiry in the same cycle.
        if (flash.flash_ack) begin
          complete = 1'b1;
          if (rd_q) begin
            rdata_d = flash.flash_rdata;
          end
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          complete       = 1'b1;
          err_d[grant_q] = 1'b1;
          rdata_d        = DATA_W'(TIMEOUT_ERR_DATA);
        end
`endif
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (complete) begin
      ack_d[grant_q] = 1'b1;
      we_d           = 1'b0;
      rd_d           = 1'b0;
      rr_ptr_d       = IDX_W'(rr_next(int'(grant_q), NUM_REQ));
      state_d        = ST_RECOVER;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
`ifdef FLASH_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign req_ack                = ack_q;
  assign req_rdata              = rdata_q;
  assign flash.flash_block_addr = addr_q;
  assign flash.flash_wdata      = wdata_q;
  assign flash.flash_we         = we_q;
  assign flash.flash_rd         = rd_q;

`ifdef FLASH_ARB_TIMEOUT_EN
  assign req_err = err_q;
`else
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - scoreboard bench for flash_arbiter (define FLASH_ARB_TIMEOUT_EN for watchdog case).
module tb_flash_arbiter;

  localparam int NR = 2;
  localparam int AW = 26;
  localparam int DW = 32;
`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req_rd, req_we, req_ack, req_err;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    req_rdata;

  logic          r_rd [NR];
  logic          r_we [NR];
  logic [AW-1:0] r_addr [NR];
  logic [DW-1:0] r_wdata [NR];

  flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fl ();

  flash_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .flash(fl)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_rd = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < NR; k++) begin
      req_rd[k]               = r_rd[k];
      req_we[k]               = r_we[k];
      req_addr[k*AW +: AW]    = r_addr[k];
      req_wdata[k*DW +: DW]   = r_wdata[k];
    end
  end

  typedef struct { int idx; logic err; logic [DW-1:0] rdata; } ack_exp_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } op_exp_t;
  ack_exp_t ack_q[$];
  op_exp_t  op_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash model: acks after ack_delay strobe cycles; stray acks on request.
  logic          ack_en = 1'b1;
  int            ack_delay = 5;
  logic [DW-1:0] model_rdata = '0;
  logic          stray_tgl = 1'b0;
  logic          stray_seen = 1'b0;
  int            fcnt = 0;

  always @(negedge clk) begin
    fl.flash_ack   = 1'b0;
    fl.flash_rdata = 32'hDEAD_BEEF;
    if (!rst) begin
      fcnt = 0;
    end else if (stray_tgl != stray_seen) begin
      stray_seen     = stray_tgl;
      fl.flash_ack   = 1'b1;
      fl.flash_rdata = 32'h5151_5151;
    end else if ((fl.flash_rd | fl.flash_we) && ack_en) begin
      if (fcnt == ack_delay - 1) begin
        fl.flash_ack   = 1'b1;
        fl.flash_rdata = model_rdata;
      end
      fcnt++;
    end else begin
      fcnt = 0;
    end
  end

  // Ack monitor.
  always @(negedge clk) begin
    ack_exp_t e;
    if (rst) begin
      if (req_ack != '0) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got %b expected none", req_ack);
        end else begin
          e = ack_q.pop_front();
          check("ack_vec", 64'(req_ack), 64'(1) << e.idx);
          check("ack_err", 64'(req_err), e.err ? (64'(1) << e.idx) : 64'(0));
          check("ack_rdata", 64'(req_rdata), 64'(e.rdata));
          check("ack_strobe_low", 64'({fl.flash_rd, fl.flash_we}), 64'(0));
        end
      end else if (req_err != '0) begin
        check("err_without_ack", 64'(req_err), 64'(0));
      end
    end
  end

  // Flash-side monitor: operation order/content and stability while strobed.
  logic          prev_strobe = 1'b0;
  logic          stable = 1'b1;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_we;

  always @(negedge clk) begin
    op_exp_t o;
    logic strobe;
    strobe = fl.flash_rd | fl.flash_we;
    if (strobe && !prev_strobe) begin
      cap_addr = fl.flash_block_addr; cap_wdata = fl.flash_wdata; cap_we = fl.flash_we;
      stable = 1'b1;
      if (op_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_op: got addr %0h expected none", fl.flash_block_addr);
      end else begin
        o = op_q.pop_front();
        check("op_addr", 64'(fl.flash_block_addr), 64'(o.addr));
        check("op_we", 64'(fl.flash_we), 64'(o.we));
        check("op_rd", 64'(fl.flash_rd), 64'(!o.we));
        if (o.we) check("op_wdata", 64'(fl.flash_wdata), 64'(o.wdata));
      end
    end else if (strobe && prev_strobe) begin
      if (fl.flash_block_addr !== cap_addr || fl.flash_we !== cap_we ||
          fl.flash_wdata !== cap_wdata) stable = 1'b0;
    end else if (!strobe && prev_strobe) begin
      check("op_stable", 64'(stable), 64'(1));
    end
    prev_strobe = strobe;
  end

  task automatic push_op(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    op_exp_t o;
    o.addr = a; o.we = we; o.wdata = d;
    op_q.push_back(o);
  endtask

  task automatic push_ack(input int i, input logic err, input logic [DW-1:0] rd);
    ack_exp_t e;
    e.idx = i; e.err = err; e.rdata = rd;
    ack_q.push_back(e);
  endtask

  task automatic run_req(input int i, input logic rd, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    r_rd[i] = rd; r_we[i] = we; r_addr[i] = a; r_wdata[i] = d;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (req_ack[i]) seen = 1'b1;
    end
    r_rd[i] = 1'b0; r_we[i] = 1'b0;
    check($sformatf("req%0d_done", i), 64'(seen), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit hi;
    int n;
    for (int k = 0; k < NR; k++) begin
      r_rd[k] = 1'b0; r_we[k] = 1'b0; r_addr[k] = '0; r_wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(req_ack), 64'(0));
    check("rst_err", 64'(req_err), 64'(0));
    check("rst_rdata", 64'(req_rdata), 64'(0));
    check("rst_strobes", 64'({fl.flash_rd, fl.flash_we}), 64'(0));
    check("rst_addr", 64'(fl.flash_block_addr), 64'(0));
    check("rst_wdata", 64'(fl.flash_wdata), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single read with latency check.
    ack_delay = 5; model_rdata = 32'hCAFE_F00D;
    push_op(26'h12, 1'b0, '0);
    push_ack(0, 1'b0, 32'hCAFE_F00D);
    fork
      run_req(0, 1'b1, 1'b0, 26'h12, '0);
      begin
        @(posedge clk); #1;
        check("lat_rd", 64'(fl.flash_rd), 64'(1));
        check("lat_addr", 64'(fl.flash_block_addr), 64'(26'h12));
      end
    join
    @(negedge clk);

    // Lone write from requester 1: read data register unchanged.
    ack_delay = 2;
    push_op(26'h2A, 1'b1, 32'h1234_5678);
    push_ack(1, 1'b0, 32'hCAFE_F00D);
    run_req(1, 1'b0, 1'b1, 26'h2A, 32'h1234_5678);
    @(negedge clk);

    // Contention: strict alternation 0,1,0,1.
    ack_delay = 3; model_rdata = 32'h1111_0000;
    push_op(26'h100, 1'b0, '0);          push_ack(0, 1'b0, 32'h1111_0000);
    push_op(26'h200, 1'b1, 32'hA000_0000); push_ack(1, 1'b0, 32'h1111_0000);
    push_op(26'h101, 1'b0, '0);          push_ack(0, 1'b0, 32'h1111_0000);
    push_op(26'h201, 1'b1, 32'hA000_0001); push_ack(1, 1'b0, 32'h1111_0000);
    fork
      begin
        run_req(0, 1'b1, 1'b0, 26'h100, '0); @(negedge clk);
        run_req(0, 1'b1, 1'b0, 26'h101, '0);
      end
      begin
        run_req(1, 1'b0, 1'b1, 26'h200, 32'hA000_0000); @(negedge clk);
        run_req(1, 1'b0, 1'b1, 26'h201, 32'hA000_0001);
      end
    join
    repeat (2) @(negedge clk);

    // Stability: address changes and request drops mid-BUSY.
    ack_delay = 6; model_rdata = 32'h0404_0404;
    push_op(26'h40, 1'b0, '0);
    push_ack(0, 1'b0, 32'h0404_0404);
    r_rd[0] = 1'b1; r_addr[0] = 26'h40;
    repeat (3) @(negedge clk);
    r_addr[0] = 26'h3FF_FFFF; r_rd[0] = 1'b0;
    hi = 1'b0;
    for (int c = 0; c < 50 && !hi; c++) begin
      @(negedge clk);
      if (req_ack[0]) hi = 1'b1;
    end
    check("stab_ack_seen", 64'(hi), 64'(1));
    hi = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (fl.flash_rd | fl.flash_we) hi = 1'b1;
    end
    check("stab_no_second", 64'(hi), 64'(0));

    // Stray ack while idle.
    stray_tgl = ~stray_tgl;
    hi = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fl.flash_rd | fl.flash_we) hi = 1'b1;
    end
    check("stray_no_strobe", 64'(hi), 64'(0));
    ack_delay = 2; model_rdata = 32'h5555_AAAA;
    push_op(26'h55, 1'b0, '0);
    push_ack(0, 1'b0, 32'h5555_AAAA);
    run_req(0, 1'b1, 1'b0, 26'h55, '0);
    @(negedge clk);

    // Async reset mid-BUSY, then a tie must go to requester 0.
    ack_delay = 30;
    push_op(26'h77, 1'b0, '0);
    r_rd[0] = 1'b1; r_addr[0] = 26'h77;
    repeat (3) @(negedge clk);
    check("arst_busy", 64'(fl.flash_rd), 64'(1));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_rd_low", 64'(fl.flash_rd), 64'(0));
    check("arst_no_ack", 64'(req_ack), 64'(0));
    @(negedge clk);
    r_rd[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_rdata", 64'(req_rdata), 64'(0));
    ack_delay = 3; model_rdata = 32'h7777_0000;
    push_op(26'h10, 1'b0, '0);             push_ack(0, 1'b0, 32'h7777_0000);
    push_op(26'h11, 1'b1, 32'hBEEF_0001);  push_ack(1, 1'b0, 32'h7777_0000);
    fork
      run_req(0, 1'b1, 1'b0, 26'h10, '0);
      run_req(1, 1'b0, 1'b1, 26'h11, 32'hBEEF_0001);
    join
    @(negedge clk);

`ifdef FLASH_ARB_TIMEOUT_EN
    // Watchdog: no flash ack for 16 busy cycles.
    ack_en = 1'b0;
    push_op(26'h99, 1'b0, '0);
    push_ack(0, 1'b1, 32'h0);
    r_rd[0] = 1'b1; r_addr[0] = 26'h99;
    n = 0; hi = 1'b0;
    for (int c = 0; c < 100 && !hi; c++) begin
      @(negedge clk);
      if (fl.flash_rd) n++;
      if (req_ack[0]) hi = 1'b1;
    end
    r_rd[0] = 1'b0;
    check("tmo_ack_seen", 64'(hi), 64'(1));
    check("tmo_busy_cycles", 64'(n), 64'(16));
    ack_en = 1'b1; ack_delay = 2; model_rdata = 32'h9A9A_9A9A;
    @(negedge clk);
    push_op(26'h9A, 1'b0, '0);
    push_ack(0, 1'b0, 32'h9A9A_9A9A);
    run_req(0, 1'b1, 1'b0, 26'h9A, '0);
`else
    n = 0;
`endif

    repeat (5) @(negedge clk);
    check("ack_queue_empty", 64'(ack_q.size()), 64'(0));
    check("op_queue_empty", 64'(op_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
